module_data_arbiter: RTL and testbench
======================================

# module_data_arbiter

Parametrised N-channel merge stage between the per-module receive FIFOs (FWFT, clk_100 domain) and the Ethernet TX FIFO. It replaces the fixed-priority combinational mux with a registered arbiter. The arbiter selects fixed-priority or round-robin at run time, tags each word with its source channel, drains disabled channels, and keeps per-channel accepted and dropped word counters readable by the MicroBlaze.

## Interface
Parameters:
- NMODULES, 4, number of frontend channels (≥2)
- LENGTH, 128, data word width
- CNT_WIDTH, 32, width of each event counter
- SRC_W, $clog2(NMODULES), width of the source tag (derived, not overridden)

Ports:
- clk  in  1  system clock (clk_100)
- rst  in  1  reset, synchronous, active-high (driven by soft_rst)
- m_en  in  NMODULES  per-channel enable (gpio_o[7:4])
- rr_mode  in  1  1 = round-robin, 0 = fixed priority (lowest index wins)
- in_valid  in  NMODULES  channel word available (~fifo_empty)
- in_ready  out  NMODULES  channel word consumed this cycle (fifo rd_en = in_valid & in_ready)
- in_data  in  LENGTH*NMODULES  channel words, channel i at [i*LENGTH +: LENGTH]
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accepts (~tx fifo full)
- out_data  out  LENGTH  merged word
- out_src  out  SRC_W  channel index of out_data
- cnt_sel  in  SRC_W+1  counter select: MSB 0 = accepted counter, 1 = dropped counter; LSBs = channel
- cnt_clear  in  1  clear all counters
- cnt_value  out  CNT_WIDTH  selected counter value

## Operation
- Eligible set: E = in_valid & m_en. The winner is the grant over E.
- Fixed mode: the lowest index in E wins.
- Round-robin mode: the first index in E strictly after last_grant, wrapping at NMODULES-1 to 0, wins.
- last_grant updates to the winner only on an accepted transfer. It updates in both modes, so a mode switch mid-stream continues fairly.
- Output register is one entry. slot_free = ~out_valid | out_ready.
- When slot_free and E is non-zero, the winner's in_ready is 1. Next cycle out_data is that channel's word, out_src is the winner index, and out_valid is 1. The winner's accepted counter increments.
- When slot_free and E is zero, out_valid drops to 0 next cycle. out_data and out_src hold their previous values.
- Disabled channels (m_en[i]=0) always get in_ready[i]=1. Any valid word on them is discarded, never forwarded, and increments dropped[i]. Disabled channels never take part in the grant.
- At most one enabled channel has in_ready=1 in any cycle.
- Counters saturate at all-ones and do not wrap.
- cnt_clear zeroes all 2*NMODULES counters next cycle. If cnt_clear and an increment occur in the same cycle, the clear wins and the counter reads 0.
- cnt_value is registered: cnt_value = counter[cnt_sel] from the previous cycle. A cnt_sel channel index ≥ NMODULES reads 0.
- rr_mode and m_en are sampled every cycle with no pipelining. A channel disabled while it holds the output register still completes that word normally.

## Timing
- Latency: 1 cycle from input transfer (in_valid & in_ready) to out_valid.
- Throughput: 1 word per cycle while out_ready=1. in_ready is combinational from in_valid, m_en, out_valid, out_ready and last_grant.
- Output stall (out_valid & ~out_ready): every enabled in_ready is 0. out_data and out_src hold stable until accepted.
- Reset values:
  - out_valid 0, out_data 0, out_src 0, cnt_value 0
  - all counters 0
  - last_grant NMODULES-1, so the first round-robin grant is channel 0
- in_ready during rst: enabled channels 0, disabled channels 1.
- Reset mid-operation discards the held output word. That word is not re-presented, and counter values before reset are lost.

## Structure
- Shared package backend_pkg holds:
  - constants NMODULES, LENGTH, CMD_LEN, SGL_FLAG_OFFSET, CMD_FLAG_OFFSET
  - the counter-select encoding (CNT_SEL_ACCEPTED=0, CNT_SEL_DROPPED=1 for the MSB)
- One sub-module, rr_grant: purely combinational masked-priority grant. Inputs: request vector, last_grant, rr_mode. Outputs: grant one-hot and grant index.
- The output register, counters and readback stay in module_data_arbiter.

## Test plan
- Reset and idle: after rst, with all in_valid=0, m_en=4'hF, check out_valid=0, in_ready=4'b0000 and cnt_value=0 for every cnt_sel.
- Fixed priority: rr_mode=0, all four channels continuously valid, out_ready=1, for 8 cycles. Require out_src=0 on every word, accepted[0]=8 and accepted[1..3]=0.
- Round-robin: rr_mode=1, all channels valid, 8 words. Require out_src sequence 0,1,2,3,0,1,2,3, each accepted counter=2, and an out_src=2 word carrying in_data[2*128 +: 128].
- Backpressure: hold out_ready=0 for 5 cycles with a word held. Require out_data/out_src stable, in_ready=0 on enabled channels, and no counter change. Release, then require one transfer per cycle.
- Disabled drain: m_en=4'b1011 with channel 2 valid for 3 cycles. Require in_ready[2]=1, no out_src=2 word, dropped[2]=3 (cnt_sel=3'b110 → 3), accepted[2]=0.
- Saturation and clear: CNT_WIDTH=4, 20 words from channel 1. Require accepted[1]=15. Then assert cnt_clear in the same cycle as an increment and require 0 on the following readback.

Source files
------------

// File: rtl/backend_pkg.sv
// backend_pkg: shared backend constants and the counter-select encoding.
package backend_pkg;
  localparam int NMODULES = 4;
  localparam int LENGTH = 128;
  localparam int CMD_LEN = 16;
  localparam int SGL_FLAG_OFFSET = 15;
  localparam int CMD_FLAG_OFFSET = 14;
  localparam logic CNT_SEL_ACCEPTED = 1'b0;
  localparam logic CNT_SEL_DROPPED = 1'b1;
endpackage

// File: rtl/module_data_arbiter_if.sv
// module_data_arbiter_if: channel inputs, merged output and counter readback of the arbiter.
interface module_data_arbiter_if #(
  parameter int NMODULES = backend_pkg::NMODULES,
  parameter int LENGTH = backend_pkg::LENGTH,
  parameter int CNT_WIDTH = 32,
  parameter int SRC_W = $clog2(NMODULES)
);
  logic [NMODULES-1:0] m_en;
  logic rr_mode;
  logic [NMODULES-1:0] in_valid;
  logic [NMODULES-1:0] in_ready;
  logic [LENGTH*NMODULES-1:0] in_data;
  logic out_valid;
  logic out_ready;
  logic [LENGTH-1:0] out_data;
  logic [SRC_W-1:0] out_src;
  logic [SRC_W:0] cnt_sel;
  logic cnt_clear;
  logic [CNT_WIDTH-1:0] cnt_value;
  modport master (
    output m_en, rr_mode, in_valid, in_data, out_ready, cnt_sel, cnt_clear,
    input in_ready, out_valid, out_data, out_src, cnt_value
  );
  modport slave (
    input m_en, rr_mode, in_valid, in_data, out_ready, cnt_sel, cnt_clear,
    output in_ready, out_valid, out_data, out_src, cnt_value
  );
endinterface

// File: rtl/rr_grant.sv
// rr_grant: combinational grant, lowest request or first request after last_grant in round-robin.
module rr_grant #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last_grant,
  input  logic         rr_mode,
  output logic [N-1:0] grant,
  output logic [W-1:0] grant_idx
);
  always_comb begin
    grant_idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (req[i]) grant_idx = W'(i);
    for (int i = N - 1; i >= 0; i--)
      if (rr_mode && req[i] && W'(i) > last_grant) grant_idx = W'(i);
    grant = |req ? N'(1) << grant_idx : '0;
  end
endmodule

// File: rtl/module_data_arbiter.sv
// module_data_arbiter: registered N-channel merge with source tagging, disabled-channel drain
// and saturating per-channel accepted/dropped counters.
module module_data_arbiter
  import backend_pkg::CNT_SEL_DROPPED;
#(
  parameter int NMODULES = backend_pkg::NMODULES,
  parameter int LENGTH = backend_pkg::LENGTH,
  parameter int CNT_WIDTH = 32
) (
  input logic clk,
  input logic rst,
  module_data_arbiter_if.slave bus
);
  localparam int SRC_W = $clog2(NMODULES);
  localparam int NSEL = 1 << SRC_W;
  logic [NMODULES-1:0] elig, grant;
  logic [SRC_W-1:0] win, last_grant;
  logic slot_free, take;
  logic [NSEL-1:0] acc_inc, drp_inc;
  logic [CNT_WIDTH-1:0] acc [NSEL];
  logic [CNT_WIDTH-1:0] drp [NSEL];
  assign elig = bus.in_valid & bus.m_en;
  assign slot_free = ~bus.out_valid | bus.out_ready;
  assign take = slot_free & |elig & ~rst;
  assign bus.in_ready = ~bus.m_en | (take ? grant : '0);
  // counter banks are padded to a power of two so out-of-range selects read a constant zero
  assign acc_inc = NSEL'(take ? grant : '0);
  assign drp_inc = NSEL'(~bus.m_en & bus.in_valid);
  rr_grant #(.N(NMODULES)) u_grant (
    .req(elig),
    .last_grant(last_grant),
    .rr_mode(bus.rr_mode),
    .grant(grant),
    .grant_idx(win)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_data <= '0;
      bus.out_src <= '0;
      bus.cnt_value <= '0;
      last_grant <= SRC_W'(NMODULES - 1);
      for (int i = 0; i < NSEL; i++) begin
        acc[i] <= '0;
        drp[i] <= '0;
      end
    end else begin
      if (slot_free) bus.out_valid <= take;
      if (take) begin
        bus.out_data <= bus.in_data[win*LENGTH +: LENGTH];
        bus.out_src <= win;
        last_grant <= win;
      end
      bus.cnt_value <= (bus.cnt_sel[SRC_W] == CNT_SEL_DROPPED) ? drp[bus.cnt_sel[SRC_W-1:0]]
                                                              : acc[bus.cnt_sel[SRC_W-1:0]];
      for (int i = 0; i < NSEL; i++) begin
        acc[i] <= bus.cnt_clear ? '0 : acc[i] + CNT_WIDTH'(acc_inc[i] & ~&acc[i]);
        drp[i] <= bus.cnt_clear ? '0 : drp[i] + CNT_WIDTH'(drp_inc[i] & ~&drp[i]);
      end
    end
  end
endmodule

// File: tb/tb_module_data_arbiter.sv
// tb_module_data_arbiter: scenario tasks plus randomized traffic checked against a queue-free behavioural model.
module tb_module_data_arbiter;
  localparam int N = 4;
  localparam int L = 128;
  localparam int CW = 4;
  localparam int MAXC = (1 << CW) - 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  module_data_arbiter_if #(.NMODULES(N), .LENGTH(L), .CNT_WIDTH(CW)) bus ();
  module_data_arbiter #(.NMODULES(N), .LENGTH(L), .CNT_WIDTH(CW)) dut (.clk(clk), .rst(rst), .bus(bus));
  int vectors = 0;
  int miscompares = 0;
  logic ov_m;
  logic [L-1:0] od_m;
  logic [1:0] os_m;
  logic [CW-1:0] cv_m;
  logic [N-1:0] exp_ready, obs_ready;
  int last_m, w_m;
  int acc_m [N];
  int drp_m [N];

  // winner: scan channels starting at 0 (fixed) or just after the last grant (round-robin)
  task automatic model_comb();
    int c;
    w_m = -1;
    if (!rst && (!ov_m || bus.out_ready))
      for (int k = 0; k < N; k++) begin
        c = bus.rr_mode ? (last_m + 1 + k) % N : k;
        if (w_m < 0 && bus.in_valid[c] && bus.m_en[c]) w_m = c;
      end
    exp_ready = ~bus.m_en;
    if (w_m >= 0) exp_ready[w_m] = 1'b1;
  endtask

  task automatic model_seq();
    int ch;
    if (rst) begin
      ov_m = 1'b0; od_m = '0; os_m = '0; cv_m = '0; last_m = N - 1;
      for (int i = 0; i < N; i++) begin acc_m[i] = 0; drp_m[i] = 0; end
    end else begin
      ch = int'(bus.cnt_sel[1:0]);
      cv_m = CW'(bus.cnt_sel[2] ? drp_m[ch] : acc_m[ch]);
      if (!ov_m || bus.out_ready) ov_m = (w_m >= 0);
      if (w_m >= 0) begin
        od_m = bus.in_data[w_m*L +: L];
        os_m = 2'(w_m);
        last_m = w_m;
        acc_m[w_m] = (acc_m[w_m] < MAXC) ? acc_m[w_m] + 1 : MAXC;
      end
      for (int i = 0; i < N; i++)
        if (!bus.m_en[i] && bus.in_valid[i]) drp_m[i] = (drp_m[i] < MAXC) ? drp_m[i] + 1 : MAXC;
      if (bus.cnt_clear)
        for (int i = 0; i < N; i++) begin acc_m[i] = 0; drp_m[i] = 0; end
    end
  endtask

  task automatic tick();
    #1;
    model_comb();
    obs_ready = bus.in_ready;
    @(posedge clk);
    model_seq();
    #1;
  endtask

  task automatic rand_data();
    for (int c = 0; c < N; c++)
      for (int w = 0; w < L / 32; w++) bus.in_data[c*L + w*32 +: 32] = $urandom();
  endtask

  task automatic read_cnt(input logic [2:0] sel, output logic [CW-1:0] v);
    bus.in_valid = '0;
    bus.cnt_sel = sel;
    tick();
    v = bus.cnt_value;
  endtask

  task automatic clear_counters();
    bus.in_valid = '0;
    bus.cnt_clear = 1'b1;
    tick();
    bus.cnt_clear = 1'b0;
  endtask

  task automatic test_reset();
    logic [CW-1:0] v;
    rst = 1'b1; bus.m_en = 4'b0101; bus.in_valid = 4'hF; rand_data();
    tick();
    vectors++;
    if (obs_ready !== 4'b1010) begin miscompares++; $display("FAIL rst_in_ready got %b want 1010", obs_ready); end
    tick();
    rst = 1'b0; bus.m_en = 4'hF; bus.in_valid = '0;
    tick();
    vectors++;
    if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL idle_out_valid got %b want 0", bus.out_valid); end
    vectors++;
    if (obs_ready !== 4'b0000) begin miscompares++; $display("FAIL idle_in_ready got %b want 0000", obs_ready); end
    for (int s = 0; s < 8; s++) begin
      read_cnt(3'(s), v);
      vectors++;
      if (v !== '0) begin miscompares++; $display("FAIL reset_cnt[%0d] got %0d want 0", s, v); end
    end
  endtask

  task automatic test_round_robin();
    logic [CW-1:0] v;
    logic [L-1:0] d2;
    bus.rr_mode = 1'b1; bus.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      bus.in_valid = 4'hF; rand_data(); d2 = bus.in_data[2*L +: L];
      tick();
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out_src !== 2'(k % 4)) begin
        miscompares++; $display("FAIL rr_src[%0d] got v=%b src=%0d want v=1 src=%0d", k, bus.out_valid, bus.out_src, k % 4);
      end
      if (k % 4 == 2) begin
        vectors++;
        if (bus.out_data !== d2) begin miscompares++; $display("FAIL rr_data2 got %h want %h", bus.out_data, d2); end
      end
    end
    for (int c = 0; c < N; c++) begin
      read_cnt(3'(c), v);
      vectors++;
      if (v !== 4'd2) begin miscompares++; $display("FAIL rr_acc[%0d] got %0d want 2", c, v); end
    end
  endtask

  task automatic test_fixed();
    logic [CW-1:0] v;
    clear_counters();
    bus.rr_mode = 1'b0; bus.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      bus.in_valid = 4'hF; rand_data();
      tick();
      vectors++;
      if (bus.out_src !== 2'd0 || bus.out_data !== od_m) begin
        miscompares++; $display("FAIL fixed_word[%0d] got src=%0d data=%h want src=0 data=%h", k, bus.out_src, bus.out_data, od_m);
      end
    end
    for (int c = 0; c < N; c++) begin
      read_cnt(3'(c), v);
      vectors++;
      if (v !== ((c == 0) ? 4'd8 : 4'd0)) begin miscompares++; $display("FAIL fixed_acc[%0d] got %0d want %0d", c, v, (c == 0) ? 8 : 0); end
    end
  endtask

  task automatic test_backpressure();
    logic [CW-1:0] v;
    logic [L-1:0] hd;
    logic [1:0] hs;
    clear_counters();
    bus.rr_mode = 1'b0; bus.out_ready = 1'b1; bus.in_valid = 4'hF; rand_data();
    tick();
    hd = bus.out_data; hs = bus.out_src;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      bus.in_valid = 4'hF; rand_data();
      tick();
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== hd || bus.out_src !== hs || obs_ready !== 4'b0000) begin
        miscompares++;
        $display("FAIL stall[%0d] got v=%b src=%0d rdy=%b data=%h want v=1 src=%0d rdy=0000 data=%h",
                 k, bus.out_valid, bus.out_src, obs_ready, bus.out_data, hs, hd);
      end
    end
    read_cnt(3'd0, v);
    vectors++;
    if (v !== 4'd1) begin miscompares++; $display("FAIL stall_acc0 got %0d want 1", v); end
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.in_valid = 4'hF; rand_data();
      tick();
      vectors++;
      if (obs_ready !== 4'b0001 || bus.out_valid !== 1'b1 || bus.out_data !== od_m) begin
        miscompares++; $display("FAIL release[%0d] got rdy=%b v=%b data=%h want rdy=0001 v=1 data=%h", k, obs_ready, bus.out_valid, bus.out_data, od_m);
      end
    end
    read_cnt(3'd0, v);
    vectors++;
    if (v !== 4'd5) begin miscompares++; $display("FAIL release_acc0 got %0d want 5", v); end
  endtask

  task automatic test_drain();
    logic [CW-1:0] v;
    clear_counters();
    bus.m_en = 4'b1011; bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.in_valid = 4'b0100; rand_data();
      tick();
      vectors++;
      if (obs_ready[2] !== 1'b1 || (bus.out_valid && bus.out_src == 2'd2)) begin
        miscompares++; $display("FAIL drain[%0d] got rdy2=%b v=%b src=%0d want rdy2=1 no src2 word", k, obs_ready[2], bus.out_valid, bus.out_src);
      end
    end
    read_cnt(3'b110, v);
    vectors++;
    if (v !== 4'd3) begin miscompares++; $display("FAIL drain_drp2 got %0d want 3", v); end
    read_cnt(3'b010, v);
    vectors++;
    if (v !== 4'd0) begin miscompares++; $display("FAIL drain_acc2 got %0d want 0", v); end
    bus.m_en = 4'hF;
  endtask

  task automatic test_saturation();
    logic [CW-1:0] v;
    clear_counters();
    bus.rr_mode = 1'b0; bus.out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      bus.in_valid = 4'b0010; rand_data();
      tick();
    end
    read_cnt(3'd1, v);
    vectors++;
    if (v !== 4'd15) begin miscompares++; $display("FAIL sat_acc1 got %0d want 15", v); end
    bus.in_valid = 4'b0010; bus.cnt_clear = 1'b1;
    tick();
    bus.cnt_clear = 1'b0;
    read_cnt(3'd1, v);
    vectors++;
    if (v !== 4'd0) begin miscompares++; $display("FAIL clear_wins got %0d want 0", v); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      rst = ($urandom_range(99) == 0);
      bus.rr_mode = 1'($urandom_range(1));
      bus.m_en = ($urandom_range(3) == 0) ? 4'($urandom()) : 4'hF;
      bus.in_valid = 4'($urandom());
      bus.out_ready = ($urandom_range(3) != 0);
      bus.cnt_sel = 3'($urandom());
      bus.cnt_clear = ($urandom_range(31) == 0);
      rand_data();
      tick();
      vectors++;
      if (obs_ready !== exp_ready || bus.out_valid !== ov_m || bus.out_src !== os_m || bus.out_data !== od_m || bus.cnt_value !== cv_m) begin
        miscompares++;
        $display("FAIL random[%0d] got rdy=%b v=%b src=%0d cnt=%0d data=%h want rdy=%b v=%b src=%0d cnt=%0d data=%h",
                 k, obs_ready, bus.out_valid, bus.out_src, bus.cnt_value, bus.out_data,
                 exp_ready, ov_m, os_m, cv_m, od_m);
      end
    end
    rst = 1'b0; bus.cnt_clear = 1'b0;
  endtask

  initial begin
    bus.m_en = 4'hF; bus.rr_mode = 1'b0; bus.in_valid = '0; bus.in_data = '0;
    bus.out_ready = 1'b1; bus.cnt_sel = '0; bus.cnt_clear = 1'b0;
    test_reset();
    test_round_robin();
    test_fixed();
    test_backpressure();
    test_drain();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
